datapath: RTL and testbench
===========================

# datapath

Register-transfer datapath driven by the 32-bit `control_signal` word from the microprogrammed control unit. It holds PC, MAR, MBR, IR, BR, ACC, MR and the ALU, and drives a 256×16 asynchronous-read memory. It returns the opcode (`data_from_ir`) and status `flags` to the control unit. Instruction word: opcode in [15:8], address operand in [7:0].

## Interface
- `DATA_W`, 16, width of MBR/BR/ACC/MR and memory words
- `ADDR_W`, 8, width of PC/MAR and memory address
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `control_signal`  in  32  one-hot-per-transfer micro-order word from the control unit
- `mem_rdata`  in  16  memory read data, combinational from `mem_addr`
- `mem_addr`  out  8  memory address, continuously equal to MAR
- `mem_wdata`  out  16  write data, continuously equal to MBR
- `mem_we`  out  1  write strobe, equal to `control_signal[12]`
- `mem_re`  out  1  read strobe, equal to `control_signal[5]`
- `data_from_ir`  out  8  opcode latched for the control unit
- `flags`  out  8  [0] Z, [1] N, [2] C, [3] V, [7:4] 0

## Operation
- All transfers selected in one cycle read pre-edge register values and commit together on the edge.
- Bit map: 0 mar2memory (accepted, no effect; address is continuous), 1 pc2mbr, 2 pc2mar, 3 mbr2pc, 4 mbr2ir, 5 memory2mbr, 6 mbr2br, 7 acc2alu and 14 br2alu (accepted, no effect; ALU operands are always ACC, BR), 8 mbr2mar, 9 reserved (ignored), 10 mbr2acc, 11 acc2mbr, 12 mbr2memory, 13 ir2cu, 15 mr2mbr, 16 alu2mbr, 17–19 car_* (ignored here), 20 pc_plus1, 21 acc_clear, 22–31 ALU ops.
- PC: mbr2pc (PC←MBR[7:0]) beats pc_plus1 (PC←PC+1, wraps 255→0).
- MAR: pc2mar beats mbr2mar (MAR←MBR[7:0]).
- MBR priority: memory2mbr (mem_rdata) > acc2mbr > alu2mbr (ALU_Q) > mr2mbr > pc2mbr (zero-extended PC).
- IR←MBR[15:8] on mbr2ir; `data_from_ir`←IR on ir2cu. BR←MBR on mbr2br.
- ACC priority: mbr2acc > ALU op > acc_clear.
- ALU ops, lowest bit index wins if several set: 22 add ACC+BR; 23 sub ACC−BR; 24 and; 25 or; 26 not ~ACC; 27 lsl ACC<<1; 28 lsr ACC>>1 (zero fill); 29 mpy signed ACC×BR → {MR,ACC} 32-bit; 30 asl ACC<<1; 31 asr ACC>>>1 (sign fill).
- Each executed op also writes ALU_Q←new ACC value.
- Z, N combinational from current ACC (Z = ACC==0, N = ACC[15]).
- C, V registered, updated only by add/sub/shift ops:
  - add: C = carry out, V = signed overflow.
  - sub: C = borrow (ACC<BR unsigned), V = signed overflow.
  - shifts: C = bit shifted out, V = 0 (asl: V = ACC[15]^ACC[14]).
  - logic/mpy clear C, V.

## Timing
- Reset (async, `rst`=0): PC, MAR, MBR, IR, BR, ACC, MR, ALU_Q, C, V, `data_from_ir` = 0; thus `flags` = 8'h01, `mem_addr` = 0, `mem_wdata` = 0.
- Reset asserted mid-instruction clears all state immediately; first edge after release acts on the current `control_signal`.
- Latency: one cycle; a bit high during cycle n is visible on registers after edge n.
- Memory write: `mem_we` is combinational from bit 12; address/data are the pre-edge MAR/MBR.
- Memory read: mem_rdata sampled into MBR at the edge ending the memory2mbr cycle.
- `data_from_ir` changes only on ir2cu edges.
- mpy writes MR and ACC on the same edge; MR is unchanged by all other ops.
- `control_signal`=0 holds all state.

## Test plan
- Reset: rst low mid-run with ACC=16'h1234 → all registers 0, flags 8'h01, mem_addr 0 without waiting for clk.
- Fetch: mem[0]=16'h0205, drive memory2mbr, mbr2ir, ir2cu, mbr2mar|pc_plus1 on consecutive cycles → MBR 16'h0205, data_from_ir 8'h02, MAR 5, PC 1.
- LOAD/ADD: mem[5]=16'h7FFF, mem[6]=1; load sequence then add → ACC 16'h8000, flags N=1, V=1, C=0, Z=0.
- Priority/simultaneity: mbr2pc|pc_plus1 with MBR=16'h0030, PC=7 → PC 8'h30; mbr2acc|addition|acc_clear → ACC=MBR.
- MPY: ACC=16'hFFFE (−2), BR=3 → {MR,ACC} = 32'hFFFF_FFFA; mr2mbr → MBR 16'hFFFF.
- Shifts/wrap: PC=255, pc_plus1 → 0; ACC=16'h8001 asr → 16'hC000, C=1; lsr → 16'h4000, C=1.

Source files
------------

// File: rtl/datapath_if.sv
// Control-unit / memory facing bundle of the datapath: micro-order word in,
// memory bus and opcode/status back out.
interface datapath_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [31:0]       control_signal;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        data_from_ir;
    logic [7:0]        flags;

    modport master (
        output control_signal, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re, data_from_ir, flags
    );

    modport slave (
        input  control_signal, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re, data_from_ir, flags
    );
endinterface

// File: rtl/datapath.sv
// Register-transfer datapath (PC, MAR, MBR, IR, BR, ACC, MR, ALU) steered by a
// 32-bit micro-order word; every selected transfer commits on the same edge.
module datapath #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    datapath_if.slave bus
);
    logic [31:0] cw;
    assign cw = bus.control_signal;

    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] mbr_q, mbr_d, br_q, br_d, acc_q, acc_d;
    logic [DATA_W-1:0] mr_q, mr_d, aluq_q, aluq_d;
    logic [7:0]        ir_q, ir_d, dfir_q, dfir_d;
    logic              c_q, c_d, v_q, v_d;

    // Bits with no datapath effect (address path is continuous, ALU operands
    // are hard-wired, car_* belong to the control unit).
    logic unused_cw;
    assign unused_cw = ^{cw[0], cw[7], cw[9], cw[14], cw[19:17]};

    // ALU op select: lowest set bit of [31:22] wins.
    logic       op_vld;
    logic [3:0] op_sel;
    always_comb begin
        op_vld = 1'b0;
        op_sel = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (cw[22+i]) begin
                op_vld = 1'b1;
                op_sel = i[3:0];
            end
        end
    end

    logic [DATA_W:0]          sum, diff;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]        alu_acc;
    logic                     alu_c, alu_v;

    assign sum  = {1'b0, acc_q} + {1'b0, br_q};
    assign diff = {1'b0, acc_q} - {1'b0, br_q};
    assign prod = $signed(acc_q) * $signed(br_q);

    always_comb begin
        alu_acc = acc_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_sel)
            4'd0: begin
                alu_acc = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (acc_q[DATA_W-1] == br_q[DATA_W-1]) &&
                          (sum[DATA_W-1] != acc_q[DATA_W-1]);
            end
            4'd1: begin
                alu_acc = diff[DATA_W-1:0];
                alu_c   = diff[DATA_W];
                alu_v   = (acc_q[DATA_W-1] != br_q[DATA_W-1]) &&
                          (diff[DATA_W-1] != acc_q[DATA_W-1]);
            end
            4'd2: alu_acc = acc_q & br_q;
            4'd3: alu_acc = acc_q | br_q;
            4'd4: alu_acc = ~acc_q;
            4'd5: begin
                alu_acc = {acc_q[DATA_W-2:0], 1'b0};
                alu_c   = acc_q[DATA_W-1];
            end
            4'd6: begin
                alu_acc = {1'b0, acc_q[DATA_W-1:1]};
                alu_c   = acc_q[0];
            end
            4'd7: alu_acc = prod[DATA_W-1:0];
            4'd8: begin
                alu_acc = {acc_q[DATA_W-2:0], 1'b0};
                alu_c   = acc_q[DATA_W-1];
                alu_v   = acc_q[DATA_W-1] ^ acc_q[DATA_W-2];
            end
            4'd9: begin
                alu_acc = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
                alu_c   = acc_q[0];
            end
            default: alu_acc = acc_q;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (cw[3])       pc_d = mbr_q[ADDR_W-1:0];
        else if (cw[20]) pc_d = pc_q + 1'b1;

        mar_d = mar_q;
        if (cw[2])      mar_d = pc_q;
        else if (cw[8]) mar_d = mbr_q[ADDR_W-1:0];

        mbr_d = mbr_q;
        if (cw[5])       mbr_d = bus.mem_rdata;
        else if (cw[11]) mbr_d = acc_q;
        else if (cw[16]) mbr_d = aluq_q;
        else if (cw[15]) mbr_d = mr_q;
        else if (cw[1])  mbr_d = {{(DATA_W-ADDR_W){1'b0}}, pc_q};

        ir_d   = cw[4]  ? mbr_q[DATA_W-1:DATA_W-8] : ir_q;
        dfir_d = cw[13] ? ir_q : dfir_q;
        br_d   = cw[6]  ? mbr_q : br_q;

        acc_d = acc_q;
        if (cw[10])      acc_d = mbr_q;
        else if (op_vld) acc_d = alu_acc;
        else if (cw[21]) acc_d = '0;

        // An op that loses ACC to mbr2acc still runs: ALU_Q, MR and C/V update.
        aluq_d = op_vld ? alu_acc : aluq_q;
        mr_d   = (op_vld && op_sel == 4'd7) ? prod[2*DATA_W-1:DATA_W] : mr_q;
        c_d    = op_vld ? alu_c : c_q;
        v_d    = op_vld ? alu_v : v_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= '0;
            mar_q  <= '0;
            mbr_q  <= '0;
            ir_q   <= '0;
            dfir_q <= '0;
            br_q   <= '0;
            acc_q  <= '0;
            mr_q   <= '0;
            aluq_q <= '0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            mar_q  <= mar_d;
            mbr_q  <= mbr_d;
            ir_q   <= ir_d;
            dfir_q <= dfir_d;
            br_q   <= br_d;
            acc_q  <= acc_d;
            mr_q   <= mr_d;
            aluq_q <= aluq_d;
            c_q    <= c_d;
            v_q    <= v_d;
        end
    end

    assign bus.mem_addr     = mar_q;
    assign bus.mem_wdata    = mbr_q;
    assign bus.mem_we       = cw[12];
    assign bus.mem_re       = cw[5];
    assign bus.data_from_ir = dfir_q;
    assign bus.flags        = {4'b0, v_q, c_q, acc_q[DATA_W-1], acc_q == '0};
endmodule

// File: tb/tb_datapath.sv
// Directed program sequences from the datapath test plan followed by random
// micro-order words, all checked against an arithmetic reference model.
module tb_datapath;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    datapath_if bus ();
    datapath dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr];

    localparam logic [31:0] PC2MBR = 32'h1 << 1,  PC2MAR = 32'h1 << 2,  MBR2PC = 32'h1 << 3;
    localparam logic [31:0] MBR2IR = 32'h1 << 4,  M2MBR  = 32'h1 << 5,  MBR2BR = 32'h1 << 6;
    localparam logic [31:0] MBR2MAR = 32'h1 << 8, MBR2ACC = 32'h1 << 10, ACC2MBR = 32'h1 << 11;
    localparam logic [31:0] IR2CU  = 32'h1 << 13, MR2MBR = 32'h1 << 15, PCP1 = 32'h1 << 20;
    localparam logic [31:0] ACCCLR = 32'h1 << 21, ADD = 32'h1 << 22, MPY = 32'h1 << 29;
    localparam logic [31:0] LSR = 32'h1 << 28,   ASR = 32'h1 << 31;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0]  m_pc, m_mar, m_ir, m_dfir;
    logic [15:0] m_mbr, m_br, m_acc, m_mr, m_aluq;
    logic        m_c, m_v;
    logic [15:0] mmem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_dfir = 0; m_mbr = 0; m_br = 0;
        m_acc = 0; m_mr = 0; m_aluq = 0; m_c = 0; m_v = 0;
    endtask

    task automatic setmem(input int a, input logic [15:0] d);
        mem[a] = d;
        mmem[a] = d;
    endtask

    // One micro-cycle of the register-transfer rules, evaluated on int arithmetic.
    task automatic model_step(input logic [31:0] cw);
        int a, b, sa, sb, r, sv, p, k;
        logic [15:0] n_acc, n_mbr, n_mr, rd;
        logic [7:0]  n_pc, n_mar;
        logic        nc, nv;
        a = int'(m_acc); b = int'(m_br);
        sa = int'($signed(m_acc)); sb = int'($signed(m_br));
        k = -1;
        for (int i = 31; i >= 22; i--) if (cw[i]) k = i;
        r = a; nc = m_c; nv = m_v; n_mr = m_mr; p = 0;
        case (k)
            22: begin r = a + b; nc = r > 65535; sv = sa + sb; nv = sv > 32767 || sv < -32768; end
            23: begin r = a - b; nc = a < b;     sv = sa - sb; nv = sv > 32767 || sv < -32768; end
            24: begin r = a & b; nc = 0; nv = 0; end
            25: begin r = a | b; nc = 0; nv = 0; end
            26: begin r = ~a;    nc = 0; nv = 0; end
            27: begin r = a * 2; nc = a >= 32768; nv = 0; end
            28: begin r = a / 2; nc = (a % 2) == 1; nv = 0; end
            29: begin p = sa * sb; r = p; n_mr = p[31:16]; nc = 0; nv = 0; end
            30: begin r = a * 2; nc = a >= 32768; sv = sa * 2; nv = sv > 32767 || sv < -32768; end
            31: begin r = sa >>> 1; nc = (a % 2) == 1; nv = 0; end
            default: ;
        endcase
        rd = mmem[m_mar];
        n_pc  = cw[3] ? m_mbr[7:0] : (cw[20] ? m_pc + 8'd1 : m_pc);
        n_mar = cw[2] ? m_pc : (cw[8] ? m_mbr[7:0] : m_mar);
        if (cw[5])       n_mbr = rd;
        else if (cw[11]) n_mbr = m_acc;
        else if (cw[16]) n_mbr = m_aluq;
        else if (cw[15]) n_mbr = m_mr;
        else if (cw[1])  n_mbr = {8'h00, m_pc};
        else             n_mbr = m_mbr;
        if (cw[10])       n_acc = m_mbr;
        else if (k >= 0)  n_acc = r[15:0];
        else if (cw[21])  n_acc = 16'h0;
        else              n_acc = m_acc;
        if (cw[12]) mmem[m_mar] = m_mbr;
        if (k >= 0) begin m_aluq = r[15:0]; m_c = nc; m_v = nv; m_mr = n_mr; end
        if (cw[13]) m_dfir = m_ir;
        if (cw[4])  m_ir = m_mbr[15:8];
        if (cw[6])  m_br = m_mbr;
        m_pc = n_pc; m_mar = n_mar; m_mbr = n_mbr; m_acc = n_acc;
    endtask

    // Starts just after a falling edge, ends on the next falling edge.
    task automatic cyc(input logic [31:0] cw);
        logic        we;
        logic [7:0]  wa;
        logic [15:0] wd;
        bus.control_signal = cw;
        #1;
        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, cw[12]});
        chk("mem_re", {31'b0, bus.mem_re}, {31'b0, cw[5]});
        we = bus.mem_we; wa = bus.mem_addr; wd = bus.mem_wdata;
        model_step(cw);
        @(posedge clk);
        @(negedge clk);
        if (we) mem[wa] = wd;
        chk("mem_addr", {24'b0, bus.mem_addr}, {24'b0, m_mar});
        chk("mem_wdata", {16'b0, bus.mem_wdata}, {16'b0, m_mbr});
        chk("data_from_ir", {24'b0, bus.data_from_ir}, {24'b0, m_dfir});
        chk("flags", {24'b0, bus.flags}, {24'b0, 4'b0, m_v, m_c, m_acc[15], m_acc == 16'h0});
    endtask

    initial begin
        bus.control_signal = 32'h0;
        for (int i = 0; i < 256; i++) setmem(i, 16'($urandom));
        m_reset();
        #1 rst = 1'b0;
        #1;
        chk("rst_flags", {24'b0, bus.flags}, 32'h01);
        chk("rst_addr", {24'b0, bus.mem_addr}, 32'h0);
        chk("rst_wdata", {16'b0, bus.mem_wdata}, 32'h0);
        chk("rst_dfir", {24'b0, bus.data_from_ir}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        setmem(8'h00, 16'h0205); setmem(8'h01, 16'h0006); setmem(8'h05, 16'h7FFF);
        setmem(8'h06, 16'h0001); setmem(8'h07, 16'h0030); setmem(8'h30, 16'hFFFE);
        setmem(8'h31, 16'h0003); setmem(8'h32, 16'h8001); setmem(8'h33, 16'h00FF);

        // Fetch
        cyc(M2MBR);            chk("fetch_mbr", {16'b0, bus.mem_wdata}, 32'h0205);
        cyc(MBR2IR);
        cyc(IR2CU);            chk("fetch_opcode", {24'b0, bus.data_from_ir}, 32'h02);
        cyc(MBR2MAR | PCP1);   chk("fetch_mar", {24'b0, bus.mem_addr}, 32'h05);
        cyc(PC2MAR);           chk("fetch_pc", {24'b0, bus.mem_addr}, 32'h01);

        // LOAD 7FFF, BR=1, ADD -> overflow into sign
        cyc(MBR2MAR);
        cyc(M2MBR);            chk("load_mbr", {16'b0, bus.mem_wdata}, 32'h7FFF);
        cyc(MBR2ACC);
        cyc(PC2MAR);
        cyc(M2MBR);
        cyc(MBR2MAR);
        cyc(M2MBR);
        cyc(MBR2BR);
        cyc(ADD);              chk("add_flags", {24'b0, bus.flags}, 32'h0A);

        // Priority: mbr2pc over pc_plus1, mbr2acc over ALU/clear
        for (int i = 0; i < 6; i++) cyc(PCP1);
        cyc(PC2MAR);
        cyc(M2MBR);
        cyc(MBR2PC | PCP1);
        cyc(PC2MAR);           chk("prio_pc", {24'b0, bus.mem_addr}, 32'h30);
        cyc(MBR2ACC | ADD | ACCCLR);
        cyc(ACC2MBR);          chk("prio_acc", {16'b0, bus.mem_wdata}, 32'h0030);

        // MPY -2 * 3
        cyc(M2MBR);
        cyc(MBR2ACC);
        cyc(PCP1);
        cyc(PC2MAR);
        cyc(M2MBR);
        cyc(MBR2BR);
        cyc(MPY);              chk("mpy_flags", {24'b0, bus.flags}, 32'h02);
        cyc(ACC2MBR);          chk("mpy_acc", {16'b0, bus.mem_wdata}, 32'hFFFA);
        cyc(MR2MBR);           chk("mpy_mr", {16'b0, bus.mem_wdata}, 32'hFFFF);

        // Shifts of 8001
        cyc(PCP1);
        cyc(PC2MAR);
        cyc(M2MBR);
        cyc(MBR2ACC);
        cyc(ASR);              chk("asr_flags", {24'b0, bus.flags}, 32'h06);
        cyc(ACC2MBR);          chk("asr_acc", {16'b0, bus.mem_wdata}, 32'hC000);
        cyc(M2MBR);
        cyc(MBR2ACC);
        cyc(LSR);              chk("lsr_flags", {24'b0, bus.flags}, 32'h04);
        cyc(ACC2MBR);          chk("lsr_acc", {16'b0, bus.mem_wdata}, 32'h4000);

        // PC wrap 255 -> 0
        cyc(PCP1);
        cyc(PC2MAR);
        cyc(M2MBR);
        cyc(MBR2PC);
        cyc(PC2MAR);           chk("pc_ff", {24'b0, bus.mem_addr}, 32'hFF);
        cyc(PCP1);
        cyc(PC2MAR);           chk("pc_wrap", {24'b0, bus.mem_addr}, 32'h00);

        // Asynchronous reset mid-cycle with ACC=1234
        setmem(8'h00, 16'h1234);
        cyc(M2MBR);
        cyc(MBR2ACC);
        cyc(IR2CU);
        #2 rst = 1'b0;
        #1;
        m_reset();
        chk("midrst_flags", {24'b0, bus.flags}, 32'h01);
        chk("midrst_addr", {24'b0, bus.mem_addr}, 32'h0);
        chk("midrst_wdata", {16'b0, bus.mem_wdata}, 32'h0);
        chk("midrst_dfir", {24'b0, bus.data_from_ir}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc(ACC2MBR);          chk("midrst_acc", {16'b0, bus.mem_wdata}, 32'h0);
        cyc(32'h0);

        // Random micro-order words
        for (int n = 0; n < 500; n++) cyc($urandom & $urandom & $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
